// File: rtl/sdram_req_bridge_pkg.sv
// Shared types for the SDRAM upstream request bridge: FSM states and the
// write-FIFO entry layout.
package sdram_req_bridge_pkg;

  localparam int unsigned REQ_ADDR_W = 25;
  localparam int unsigned REQ_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } bridge_state_t;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Synchronous FIFO with occupancy count; the head entry is visible
// combinationally so the consumer can latch it in the same cycle it pops.
module sdram_req_fifo
  import sdram_req_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = sdram_req_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  entry_t           wdata_i,
  input  logic             pop_i,
  output entry_t           rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q;
  logic [PTR_W-1:0]   rptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Storage array; flushing is done through the pointers, so no reset here.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_bridge.sv
// Upstream request bridge for one 8-bit SDRAM controller channel: buffers
// byte writes, serialises single-outstanding reads, and drives the
// controller's edge-triggered rd/wr + busy handshake with a mandatory gap.
module sdram_req_bridge
  import sdram_req_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 25
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [7:0]                  wr_data,
  input  logic                        rd_valid,
  output logic                        rd_ready,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [7:0]                  rd_data,
  output logic                        rd_data_valid,
  output logic                        idle,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [ADDR_W-1:0]           ch_addr,
  output logic                        ch_rd,
  output logic                        ch_wr,
  output logic [7:0]                  ch_din,
  input  logic [7:0]                  ch_dout,
  input  logic                        ch_busy
);

  sdram_req_t    push_entry;
  sdram_req_t    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  bridge_state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic          is_rd_q, is_rd_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rdv_q, rdv_d;

  assign push_entry = '{addr: REQ_ADDR_W'(wr_addr), data: wr_data};

  sdram_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (sdram_req_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_valid),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign wr_ready = !fifo_full;
  assign idle     = fifo_empty && (state_q == ST_IDLE);

  // Request selection and channel handshake sequencing; writes take priority
  // so a read can never overtake a buffered write.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    is_rd_d  = is_rd_q;
    rdata_d  = rdata_q;
    rdv_d    = 1'b0;
    fifo_pop = 1'b0;
    rd_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        rd_ready = fifo_empty;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = ADDR_W'(head.addr);
          din_d    = head.data;
          wr_d     = 1'b1;
          is_rd_d  = 1'b0;
          state_d  = ST_ISSUE;
        end else if (rd_valid) begin
          addr_d   = rd_addr;
          rd_d     = 1'b1;
          is_rd_d  = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ch_busy) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ch_busy) begin
          if (is_rd_q) begin
            rdata_d = ch_dout;
            rdv_d   = 1'b1;
          end
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered channel/read-result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      is_rd_q <= 1'b0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      is_rd_q <= is_rd_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end

  assign ch_addr       = addr_q;
  assign ch_din        = din_q;
  assign ch_rd         = rd_q;
  assign ch_wr         = wr_q;
  assign rd_data       = rdata_q;
  assign rd_data_valid = rdv_q;

endmodule

// File: tb/tb_sdram_req_bridge.sv
// Scoreboard bench for sdram_req_bridge: a reference memory/queue model
// predicts every channel request and read result; a controller model
// answers the rd/wr strobes with configurable arbitration delay and busy.
`timescale 1ns/1ps
module tb_sdram_req_bridge;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_data_valid;
  logic          idle;
  logic [4:0]    fifo_count;
  logic [AW-1:0] ch_addr;
  logic          ch_rd;
  logic          ch_wr;
  logic [7:0]    ch_din;
  logic [7:0]    ch_dout = 8'h00;
  logic          ch_busy = 1'b0;

  always #5 clk = ~clk;

  sdram_req_bridge #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_W     (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .idle          (idle),
    .fifo_count    (fifo_count),
    .ch_addr       (ch_addr),
    .ch_rd         (ch_rd),
    .ch_wr         (ch_wr),
    .ch_din        (ch_din),
    .ch_dout       (ch_dout),
    .ch_busy       (ch_busy)
  );

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } req_t;

  req_t       exp_req [$];
  logic [7:0] exp_rd  [$];
  logic [7:0] ref_mem [logic [AW-1:0]];
  logic [7:0] bfm_mem [logic [AW-1:0]];
  req_t       mon_e;

  int checks   = 0;
  int failures = 0;
  int n_push   = 0;
  int n_wrise  = 0;
  int n_rrise  = 0;
  int n_rdv    = 0;
  bit saw_full_block = 0;
  bit prev_wr = 0, prev_rd = 0, prev_rdv = 0;

  // controller model state
  int bfm_phase = 0;
  int bfm_cnt   = 0;
  int bfm_hold  = 1;
  bit bfm_prev  = 0;
  bit bfm_is_rd = 0;
  logic [AW-1:0] bfm_addr = '0;
  logic [7:0]    bfm_din  = '0;
  int cfg_delay  = 1;
  int cfg_hold   = 1;
  bit cfg_random = 0;

  // unwritten locations read back as a fixed function of the address
  function automatic logic [7:0] dflt(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hC3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Controller channel model: detects strobe rising edges, waits an
  // arbitration delay, holds busy, then completes the access.
  always @(negedge clk) begin
    if (reset) begin
      bfm_phase = 0;
      ch_busy   = 1'b0;
      bfm_prev  = 1'b0;
      bfm_mem.delete();
    end else begin
      if (bfm_phase == 0) begin
        if ((ch_wr || ch_rd) && !bfm_prev) begin
          bfm_is_rd = ch_rd;
          bfm_addr  = ch_addr;
          bfm_din   = ch_din;
          if (cfg_random) begin
            bfm_cnt  = int'($urandom_range(3, 0));
            bfm_hold = int'($urandom_range(4, 1));
          end else begin
            bfm_cnt  = cfg_delay;
            bfm_hold = cfg_hold;
          end
          bfm_phase = 1;
        end
      end else if (bfm_phase == 1) begin
        bfm_cnt--;
      end
      if (bfm_phase == 1) begin
        check("strobe_held", {31'd0, (bfm_is_rd ? ch_rd : ch_wr)}, 32'd1);
        if (bfm_cnt <= 0) begin
          ch_busy   = 1'b1;
          bfm_cnt   = bfm_hold;
          bfm_phase = 2;
        end
      end else if (bfm_phase == 2) begin
        check("strobe_dropped", {31'd0, (ch_rd | ch_wr)}, 32'd0);
        bfm_cnt--;
        if (bfm_cnt <= 0) begin
          ch_busy = 1'b0;
          if (bfm_is_rd) begin
            ch_dout = bfm_mem.exists(bfm_addr) ? bfm_mem[bfm_addr] : dflt(bfm_addr);
          end else begin
            bfm_mem[bfm_addr] = bfm_din;
          end
          bfm_phase = 0;
        end
      end
      bfm_prev = ch_wr || ch_rd;
    end
  end

  // Monitor: compares launched requests and read results against the
  // scoreboard, then records handshakes that complete on the next edge.
  always @(negedge clk) begin
    if (reset) begin
      exp_req.delete();
      exp_rd.delete();
      ref_mem.delete();
      n_push  = 0;
      n_wrise = 0;
      n_rrise = 0;
      prev_wr = 1'b0;
      prev_rd = 1'b0;
      prev_rdv = 1'b0;
    end else begin
      check("strobe_exclusive", {31'd0, (ch_wr & ch_rd)}, 32'd0);
      if ((ch_wr && !prev_wr) || (ch_rd && !prev_rd)) begin
        if (ch_wr) n_wrise++;
        else       n_rrise++;
        if (exp_req.size() == 0) begin
          fail("unexpected_request");
        end else begin
          mon_e = exp_req.pop_front();
          check("launch_is_rd", {31'd0, ch_rd}, {31'd0, mon_e.is_rd});
          check("launch_addr", 32'(ch_addr), 32'(mon_e.addr));
          if (!mon_e.is_rd) check("launch_din", 32'(ch_din), 32'(mon_e.data));
        end
      end
      check("fifo_count", 32'(fifo_count), 32'(n_push - n_wrise));
      check("wr_ready", {31'd0, wr_ready}, {31'd0, (fifo_count < DEPTH)});
      check("rd_ready_vs_idle", {31'd0, rd_ready}, {31'd0, idle});
      if (rd_data_valid) begin
        n_rdv++;
        if (prev_rdv) fail("rdv_not_single_pulse");
        if (exp_rd.size() == 0) fail("unexpected_rd_data_valid");
        else check("rd_data", 32'(rd_data), 32'(exp_rd.pop_front()));
      end
      if (wr_valid && !wr_ready && fifo_count == 5'(DEPTH)) saw_full_block = 1'b1;
      prev_wr  = ch_wr;
      prev_rd  = ch_rd;
      prev_rdv = rd_data_valid;
      if (rd_valid && rd_ready) begin
        exp_req.push_back('{is_rd: 1'b1, addr: rd_addr, data: 8'h00});
        exp_rd.push_back(ref_mem.exists(rd_addr) ? ref_mem[rd_addr] : dflt(rd_addr));
      end
      if (wr_valid && wr_ready) begin
        ref_mem[wr_addr] = wr_data;
        exp_req.push_back('{is_rd: 1'b0, addr: wr_addr, data: wr_data});
        n_push++;
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 1'b0;
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 1000) begin
        fail("write_accept_timeout");
        acc = 1'b1;
      end
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int unsigned n;
    bit acc;
    n = 0;
    acc = 1'b0;
    rd_addr  = a;
    rd_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = rd_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 1000) begin
        fail("read_accept_timeout");
        acc = 1'b1;
      end
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_quiet(input int unsigned max_cycles);
    int unsigned n;
    int unsigned stable;
    n = 0;
    stable = 0;
    while (stable < 3) begin
      @(negedge clk);
      n++;
      if (idle && bfm_phase == 0 && !ch_busy && exp_req.size() == 0 && exp_rd.size() == 0)
        stable++;
      else
        stable = 0;
      if (n > max_cycles) begin
        fail("quiet_timeout");
        stable = 3;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int rdv_base;
    int unsigned n;
    bit found;
    reset    = 1'b1;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch_wr", {31'd0, ch_wr}, 32'd0);
    check("rst_ch_rd", {31'd0, ch_rd}, 32'd0);
    check("rst_ch_addr", 32'(ch_addr), 32'd0);
    check("rst_ch_din", 32'(ch_din), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rdv", {31'd0, rd_data_valid}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single write
    cfg_delay = 2;
    cfg_hold  = 4;
    base = n_wrise;
    do_write(25'h0001234, 8'hA5);
    wr_valid = 1'b0;
    wait_quiet(200);
    check("single_wr_launches", 32'(n_wrise - base), 32'd1);
    check("single_idle", {31'd0, idle}, 32'd1);
    check("single_ch_addr", 32'(ch_addr), 32'h0001234);
    check("single_ch_din", 32'(ch_din), 32'hA5);

    // burst of 20 writes against a slow controller
    cfg_delay = 3;
    cfg_hold  = 6;
    saw_full_block = 1'b0;
    base = n_wrise;
    for (int i = 0; i < 20; i++) begin
      do_write(AW'(32'h100 + i), 8'(8'h30 + i));
    end
    wr_valid = 1'b0;
    wait_quiet(3000);
    check("burst_launches", 32'(n_wrise - base), 32'd20);
    check("burst_full_blocked", {31'd0, saw_full_block}, 32'd1);

    // read-after-write ordering
    cfg_delay = 1;
    cfg_hold  = 2;
    rdv_base = n_rdv;
    do_write(25'h10, 8'h5A);
    wr_valid = 1'b0;
    do_read(25'h10);
    wait_quiet(300);
    check("raw_rdv_pulses", 32'(n_rdv - rdv_base), 32'd1);
    check("raw_rd_data", 32'(rd_data), 32'h5A);

    // long arbitration delay on a read
    cfg_delay = 30;
    cfg_hold  = 2;
    base = n_rrise;
    rdv_base = n_rdv;
    do_read(25'h77);
    wait_quiet(300);
    check("arb_rd_launches", 32'(n_rrise - base), 32'd1);
    check("arb_rdv_pulses", 32'(n_rdv - rdv_base), 32'd1);

    // randomized mix of writes and reads
    cfg_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) != 0) begin
        do_write(AW'($urandom_range(15, 0)), 8'($urandom));
        if ($urandom_range(2, 0) == 0) begin
          wr_valid = 1'b0;
          repeat ($urandom_range(2, 0)) @(posedge clk);
          #1;
        end
      end else begin
        wr_valid = 1'b0;
        do_read(AW'($urandom_range(15, 0)));
      end
    end
    wr_valid = 1'b0;
    wait_quiet(4000);
    cfg_random = 1'b0;

    // reset while waiting on busy with five writes queued
    cfg_delay = 0;
    cfg_hold  = 30;
    for (int i = 0; i < 6; i++) begin
      do_write(AW'(32'h200 + i), 8'(8'h60 + i));
    end
    wr_valid = 1'b0;
    n = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      @(negedge clk);
      n++;
      if (bfm_phase == 2 && !ch_wr && fifo_count == 5'd5) found = 1'b1;
    end
    if (!found) fail("reset_setup_timeout");
    #2;
    reset = 1'b1;
    #1;
    check("arst_ch_wr", {31'd0, ch_wr}, 32'd0);
    check("arst_ch_rd", {31'd0, ch_rd}, 32'd0);
    check("arst_ch_addr", 32'(ch_addr), 32'd0);
    check("arst_ch_din", 32'(ch_din), 32'd0);
    check("arst_rd_data", 32'(rd_data), 32'd0);
    check("arst_rdv", {31'd0, rd_data_valid}, 32'd0);
    check("arst_fifo_count", 32'(fifo_count), 32'd0);
    check("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
    check("arst_idle", {31'd0, idle}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    rdv_base = n_rdv;
    repeat (40) @(posedge clk);
    #1;
    check("post_rst_wr_launches", 32'(n_wrise), 32'd0);
    check("post_rst_rd_launches", 32'(n_rrise), 32'd0);
    check("post_rst_rdv", 32'(n_rdv - rdv_base), 32'd0);
    check("post_rst_idle", {31'd0, idle}, 32'd1);
    check("post_rst_fifo_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
